mig_ui_responder: RTL and testbench
===================================

Name: mig_ui_responder

Overview:
- Synthesizable, simulation-grade stand-in for the Series 7 MIG user interface: the responder side of the app_* command/write/read protocol driven by the memory arbiter.
- Backed by a small on-chip memory with a calibration delay, fixed read latency, optional pseudo-random app_rdy back-pressure and a sticky protocol checker.
- Lets arbiter, camera and host-transfer paths run in RTL simulation and on-board bring-up without DDR.

Parameters:
- ADDR_WIDTH, 29, app_addr width.
- DATA_WIDTH, 256, app_wdf_data / app_rd_data width.
- MASK_WIDTH, 32, DATA_WIDTH/8, byte mask width.
- MEM_DEPTH_LOG2, 8, log2 of burst entries stored.
- CALIB_CYCLES, 64, cycles after reset before init_calib_complete rises.
- RD_LATENCY, 8, cycles from accepted read to app_rd_data_valid; must be at least 2.
- WDF_DEPTH_LOG2, 2, write-data FIFO depth is 4.
- STALL_EN, 0, 1 enables LFSR back-pressure on app_rdy.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- init_calib_complete  out  1  calibration done
- app_en  in  1  command valid
- app_cmd  in  3  000 write, 001 read
- app_addr  in  ADDR_WIDTH  burst address
- app_rdy  out  1  command accepted when app_en & app_rdy
- app_wdf_data  in  DATA_WIDTH  write data
- app_wdf_mask  in  MASK_WIDTH  1 = byte not written
- app_wdf_wren  in  1  write-data valid
- app_wdf_end  in  1  last beat; must equal app_wdf_wren
- app_wdf_rdy  out  1  write-data accepted when app_wdf_wren & app_wdf_rdy
- app_rd_data  out  DATA_WIDTH  read data
- app_rd_data_valid  out  1  read data valid
- app_rd_data_end  out  1  equals app_rd_data_valid
- proto_err  out  1  sticky protocol error
- err_code  out  2  first error seen: 1 no write data, 2 misaligned addr, 3 bad cmd

Behaviour:
- Reset values: init_calib_complete=0, app_rdy=0, app_wdf_rdy=0, app_rd_data_valid=0, app_rd_data_end=0, app_rd_data=0, proto_err=0, err_code=0. Memory contents are not cleared.
- LFSR is reset to 16'hACE1.
- Calibration:
  - A counter runs from reset.
  - init_calib_complete is registered and rises at reset-release + CALIB_CYCLES.
  - app_rdy and app_wdf_rdy stay 0 until init_calib_complete=1.
- app_rdy = calib & (read pipe occupancy < RD_LATENCY) & (STALL_EN ? lfsr[0] : 1). It is registered and never depends combinationally on app_en.
- app_wdf_rdy = calib & wdf FIFO not full. Registered, from next-cycle occupancy.
- Write data: a wren&wdf_rdy beat pushes {data,mask}. If wdf_end != wren, set error 1 and still push.
- Command acceptance: one command per cycle, processed strictly in acceptance order.
- Address index is app_addr[3 +: MEM_DEPTH_LOG2]. Upper bits alias. app_addr[2:0] != 0 sets error 2; the command still executes with bits [2:0] ignored.
- Write command:
  - Pops the wdf head in the same cycle.
  - Writes every byte whose mask bit is 0.
  - If the FIFO is empty at acceptance, set error 1 and perform no write.
  - A push and a pop in the same cycle leave the count unchanged.
  - There is no same-cycle bypass into an empty FIFO.
- Read command:
  - Reads memory in the acceptance cycle, so read-after-write ordering holds.
  - Data enters a RD_LATENCY-stage pipeline.
  - Read accepted at cycle N gives app_rd_data_valid=app_rd_data_end=1 at N+RD_LATENCY for exactly one cycle.
  - Back-to-back accepts give back-to-back valids with no bubbles.
- Other app_cmd values set error 3; no memory effect.
- Errors: proto_err latches on the first error. err_code holds that first error until reset.
- Reset mid-operation: all in-flight reads are discarded, valid=0 next cycle, the wdf FIFO is emptied, and calibration restarts.

Decomposition:
- Package mig_ui_pkg:
  - CMD_WRITE=3'b000, CMD_READ=3'b001.
  - ERR_NONE/ERR_NO_WDATA/ERR_MISALIGN/ERR_BAD_CMD.
  - Default widths.
- Sub-module ui_wdf_fifo: synchronous FIFO with parameters WIDTH=DATA_WIDTH+MASK_WIDTH and DEPTH_LOG2; outputs full, empty, count.
- Memory array and read pipeline stay in the top module.

Test Plan:
- Reset, idle -> init_calib_complete rises exactly at cycle 64; app_rdy/app_wdf_rdy 0 before, 1 after (STALL_EN=0).
- wren with data=256'h0123..EF, then write cmd addr 0x40, then read cmd addr 0x40 at cycle N -> valid/end at N+8 with data 256'h0123..EF; proto_err=0.
- Write all-1s to 0x0, then write 0 with mask=32'hFFFFFFFE to 0x0, read 0x0 -> 256'hFF..FF00.
- 4 wren beats with no cmd -> app_wdf_rdy=0 after 4th; a write cmd pops one and wdf_rdy returns 1 the next cycle.
- 12 back-to-back reads -> app_rdy drops after 8 outstanding; 12 valids in order, no data loss.
- Write cmd with empty FIFO -> proto_err=1, err_code=1; a later misaligned addr 0x43 leaves err_code=1. Reset mid-read -> no valid afterwards and proto_err cleared.

Source files
------------

// File: rtl/mig_ui_pkg.sv
// mig_ui_pkg
//   Shared command encodings, error codes and default widths for the
//   MIG user-interface responder and its write-data FIFO.
package mig_ui_pkg;

  localparam int DEF_ADDR_WIDTH     = 29;
  localparam int DEF_DATA_WIDTH     = 256;
  localparam int DEF_MASK_WIDTH     = DEF_DATA_WIDTH / 8;
  localparam int DEF_MEM_DEPTH_LOG2 = 8;
  localparam int DEF_CALIB_CYCLES   = 64;
  localparam int DEF_RD_LATENCY     = 8;
  localparam int DEF_WDF_DEPTH_LOG2 = 2;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_NO_WDATA = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_BAD_CMD  = 2'd3
  } err_code_e;

  // Galois LFSR used for optional app_rdy back-pressure.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mig_ui_responder_wdf_fifo.sv
// ui_wdf_fifo
//   Synchronous FIFO holding {data, mask} write-data beats until a write
//   command consumes them. Push while full and pop while empty are ignored.
//   Ports:
//     clk, reset      clock, synchronous active-high reset (empties FIFO)
//     push, push_data write one entry
//     pop             drop the head entry
//     head            current head entry (valid when !empty)
//     full, empty     occupancy flags
//     count           number of stored entries (0..2**DEPTH_LOG2)
module ui_wdf_fifo
  import mig_ui_pkg::*;
#(
  parameter int WIDTH      = DEF_DATA_WIDTH + DEF_MASK_WIDTH,
  parameter int DEPTH_LOG2 = DEF_WDF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** DEPTH_LOG2);

  logic [WIDTH-1:0]      store [2 ** DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (cnt == DEPTH);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = store[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mig_ui_responder.sv
// mig_ui_responder
//   Simulation-grade stand-in for the Series 7 MIG user interface. Accepts
//   app_* write/read commands into a small on-chip memory, returns read data
//   after a fixed latency, models calibration delay and optional app_rdy
//   back-pressure, and latches the first protocol error it sees.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     init_calib_complete        high CALIB_CYCLES cycles after reset release
//     app_en/app_cmd/app_addr    command channel, accepted on app_en & app_rdy
//     app_rdy                    registered command ready
//     app_wdf_*                  write-data channel into the wdf FIFO
//     app_rd_data*               read return, one beat per accepted read
//     proto_err, err_code        sticky first-error flag and its code
module mig_ui_responder
  import mig_ui_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH     = DEF_MASK_WIDTH,
  parameter int MEM_DEPTH_LOG2 = DEF_MEM_DEPTH_LOG2,
  parameter int CALIB_CYCLES   = DEF_CALIB_CYCLES,
  parameter int RD_LATENCY     = DEF_RD_LATENCY,
  parameter int WDF_DEPTH_LOG2 = DEF_WDF_DEPTH_LOG2,
  parameter int STALL_EN       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_calib_complete,
  input  logic                  app_en,
  input  logic [2:0]            app_cmd,
  input  logic [ADDR_WIDTH-1:0] app_addr,
  output logic                  app_rdy,
  input  logic [DATA_WIDTH-1:0] app_wdf_data,
  input  logic [MASK_WIDTH-1:0] app_wdf_mask,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_wdf_rdy,
  output logic [DATA_WIDTH-1:0] app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  output logic                  proto_err,
  output logic [1:0]            err_code
);

  localparam int FIFO_W    = DATA_WIDTH + MASK_WIDTH;
  localparam int WDF_CW    = WDF_DEPTH_LOG2 + 1;
  localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);
  localparam logic [WDF_CW-1:0] WDF_DEPTH = WDF_CW'(2 ** WDF_DEPTH_LOG2);

  // calibration: down-counter, done flag rises on the edge after terminal count
  logic [CAL_W-1:0] cal_cnt;
  logic             calib_q;
  logic             calib_next;

  assign calib_next = calib_q | (cal_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cal_cnt <= CAL_W'(CALIB_CYCLES - 1);
      calib_q <= 1'b0;
    end else begin
      calib_q <= calib_next;
      if (cal_cnt != '0) cal_cnt <= cal_cnt - CAL_W'(1);
    end
  end

  assign init_calib_complete = calib_q;

  // back-pressure LFSR
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_next;

  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next;
  end

  // command decode
  logic                      cmd_acc;
  logic                      is_wr;
  logic                      is_rd;
  logic                      is_bad;
  logic [MEM_DEPTH_LOG2-1:0] mem_idx;
  logic                      unused_addr_bits;

  assign cmd_acc = app_en & app_rdy;
  assign is_wr   = cmd_acc & (app_cmd == CMD_WRITE);
  assign is_rd   = cmd_acc & (app_cmd == CMD_READ);
  assign is_bad  = cmd_acc & ~(app_cmd == CMD_WRITE) & ~(app_cmd == CMD_READ);
  assign mem_idx = app_addr[3 +: MEM_DEPTH_LOG2];
  // upper address bits alias onto the same small memory
  assign unused_addr_bits = ^app_addr[ADDR_WIDTH-1:3+MEM_DEPTH_LOG2];

  // write-data FIFO
  logic                  wdf_push;
  logic                  wdf_pop;
  logic [FIFO_W-1:0]     wdf_head;
  logic                  wdf_full;
  logic                  wdf_empty;
  logic [WDF_CW-1:0]     wdf_count;
  logic [WDF_CW-1:0]     wdf_cnt_next;
  logic [DATA_WIDTH-1:0] wdf_head_data;
  logic [MASK_WIDTH-1:0] wdf_head_mask;

  assign wdf_push = app_wdf_wren & app_wdf_rdy & ~wdf_full;
  // no bypass: a beat pushed this cycle cannot satisfy a write accepted this cycle
  assign wdf_pop  = is_wr & ~wdf_empty;
  assign {wdf_head_data, wdf_head_mask} = wdf_head;

  ui_wdf_fifo #(
    .WIDTH      (FIFO_W),
    .DEPTH_LOG2 (WDF_DEPTH_LOG2)
  ) u_wdf_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wdf_push),
    .push_data ({app_wdf_data, app_wdf_mask}),
    .pop       (wdf_pop),
    .head      (wdf_head),
    .full      (wdf_full),
    .empty     (wdf_empty),
    .count     (wdf_count)
  );

  // memory array, byte-masked writes, not cleared by reset
  logic [DATA_WIDTH-1:0] mem [2 ** MEM_DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wdf_pop) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!wdf_head_mask[b]) mem[mem_idx][8*b +: 8] <= wdf_head_data[8*b +: 8];
      end
    end
  end

  // read pipeline: memory sampled at acceptance, then RD_LATENCY stages
  logic [RD_LATENCY-1:0] rd_vld;
  logic [RD_LATENCY-1:0] vld_next;
  logic [DATA_WIDTH-1:0] rd_pipe [RD_LATENCY];
  int                    occ_next;

  assign vld_next = {rd_vld[RD_LATENCY-2:0], is_rd};

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      rd_vld     <= vld_next;
      rd_pipe[0] <= is_rd ? mem[mem_idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign app_rd_data       = rd_pipe[RD_LATENCY-1];
  assign app_rd_data_valid = rd_vld[RD_LATENCY-1];
  assign app_rd_data_end   = rd_vld[RD_LATENCY-1];

  // ready flags come from next-cycle occupancy so they are pure registers
  always_comb begin
    occ_next     = $countones(vld_next);
    wdf_cnt_next = wdf_count + WDF_CW'(wdf_push) - WDF_CW'(wdf_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      app_rdy     <= 1'b0;
      app_wdf_rdy <= 1'b0;
    end else begin
      app_rdy     <= calib_next && (occ_next < RD_LATENCY) && ((STALL_EN == 0) || lfsr_next[0]);
      app_wdf_rdy <= calib_next && (wdf_cnt_next < WDF_DEPTH);
    end
  end

  // protocol checker, first error wins
  err_code_e err_new;
  err_code_e err_q;

  always_comb begin
    err_new = ERR_NONE;
    if ((app_wdf_end != app_wdf_wren) || (is_wr && wdf_empty)) begin
      err_new = ERR_NO_WDATA;
    end else if (is_bad) begin
      err_new = ERR_BAD_CMD;
    end else if ((is_wr || is_rd) && (app_addr[2:0] != 3'b000)) begin
      err_new = ERR_MISALIGN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
      err_q     <= ERR_NONE;
    end else if (!proto_err && (err_new != ERR_NONE)) begin
      proto_err <= 1'b1;
      err_q     <= err_new;
    end
  end

  assign err_code = err_q;

endmodule

// File: tb/tb_mig_ui_responder.sv
module tb_mig_ui_responder;
  import mig_ui_pkg::*;

  localparam int AW     = 29;
  localparam int DW     = 256;
  localparam int MW     = 32;
  localparam int RD_LAT = 8;
  localparam int CAL    = 64;

  logic          clk;
  logic          reset;
  logic          init_calib_complete;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          proto_err;
  logic [1:0]    err_code;

  mig_ui_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .MEM_DEPTH_LOG2(8),
    .CALIB_CYCLES(CAL), .RD_LATENCY(RD_LAT), .WDF_DEPTH_LOG2(2), .STALL_EN(0)
  ) dut (
    .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .proto_err(proto_err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  logic [DW-1:0] d0, d_ones, d_b, d_a, d_c;
  logic [DW-1:0] fb[4];
  logic [AW-1:0] rb_addr[8];
  logic [DW-1:0] rb_exp[8];
  int            first_stall;
  int            valid_base;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard consumer: every valid beat must match the oldest outstanding read
  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        note_fail("unexpected_valid");
      end else begin
        mon_e = sb_q.pop_front();
        chk("rd_data", app_rd_data, mon_e.data);
        chk("rd_latency", DW'(cyc), DW'(mon_e.due));
        chk("rd_end", DW'(app_rd_data_end), DW'(1));
      end
    end
  end

  task automatic push_wdf(input logic [DW-1:0] data, input logic [MW-1:0] mask);
    int n = 0;
    while (!app_wdf_rdy && n < 200) begin step(); n++; end
    if (!app_wdf_rdy) begin note_fail("wdf_rdy_timeout"); return; end
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1;
    app_wdf_data = data; app_wdf_mask = mask;
    step();
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr,
                          input logic [DW-1:0] exp, input bit is_rd);
    int n = 0;
    while (!app_rdy && n < 200) begin step(); n++; end
    if (!app_rdy) begin note_fail("app_rdy_timeout"); return; end
    app_en = 1'b1; app_cmd = cmd; app_addr = addr;
    if (is_rd) sb_q.push_back('{data: exp, due: cyc + RD_LAT});
    step();
    app_en = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin step(); n++; end
    if (sb_q.size() != 0) begin note_fail("drain_timeout"); sb_q.delete(); end
  endtask

  task automatic reset_calib(input bit check);
    app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    reset = 1'b1;
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    if (check) begin
      chk("rst_calib", DW'(init_calib_complete), DW'(0));
      chk("rst_app_rdy", DW'(app_rdy), DW'(0));
      chk("rst_wdf_rdy", DW'(app_wdf_rdy), DW'(0));
      chk("rst_valid", DW'(app_rd_data_valid), DW'(0));
      chk("rst_rd_data", app_rd_data, '0);
      chk("rst_proto_err", DW'(proto_err), DW'(0));
      chk("rst_err_code", DW'(err_code), DW'(0));
    end
    repeat (CAL - 1) step();
    if (check) begin
      chk("calib_before", DW'(init_calib_complete), DW'(0));
      chk("app_rdy_before", DW'(app_rdy), DW'(0));
      chk("wdf_rdy_before", DW'(app_wdf_rdy), DW'(0));
    end
    step();
    if (check) begin
      chk("calib_at", DW'(init_calib_complete), DW'(1));
      chk("app_rdy_at", DW'(app_rdy), DW'(1));
      chk("wdf_rdy_at", DW'(app_wdf_rdy), DW'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; app_en = 1'b0; app_cmd = '0; app_addr = '0;
    app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;

    d0     = {4{64'h0123456789ABCDEF}};
    d_ones = '1;
    d_a    = {8{32'hA5A5_0001}};
    d_b    = {16{16'h5B5B}};
    d_c    = {4{64'hC0FFEE00_DEADBEEF}};
    vecs[0] = '{waddr: 29'h40,  raddr: 29'h40,  wdata: d0,     mask: 32'h0,        exp: d0};
    vecs[1] = '{waddr: 29'h0,   raddr: 29'h0,   wdata: d_ones, mask: 32'h0,        exp: d_ones};
    vecs[2] = '{waddr: 29'h0,   raddr: 29'h0,   wdata: '0,     mask: 32'hFFFFFFFE, exp: {{31{8'hFF}}, 8'h00}};
    vecs[3] = '{waddr: 29'h808, raddr: 29'h8,   wdata: d_a,    mask: 32'h0,        exp: d_a};
    vecs[4] = '{waddr: 29'h40,  raddr: 29'h40,  wdata: d_b,    mask: 32'h0000FFFF, exp: {d_b[255:128], d0[127:0]}};
    vecs[5] = '{waddr: 29'h7F8, raddr: 29'h7F8, wdata: d_c,    mask: 32'h0,        exp: d_c};
    for (int i = 0; i < 4; i++) fb[i] = {8{32'hF1F0_0000 | 32'(i)}};
    rb_addr = '{29'h0, 29'h8, 29'h40, 29'h7F8, 29'h10, 29'h18, 29'h20, 29'h28};
    rb_exp  = '{vecs[2].exp, vecs[3].exp, vecs[4].exp, vecs[5].exp, fb[0], fb[1], fb[2], fb[3]};

    reset_calib(1);

    for (int v = 0; v < 6; v++) begin
      push_wdf(vecs[v].wdata, vecs[v].mask);
      send_cmd(CMD_WRITE, vecs[v].waddr, '0, 0);
      send_cmd(CMD_READ, vecs[v].raddr, vecs[v].exp, 1);
      wait_drain();
      chk("vec_proto_err", DW'(proto_err), DW'(0));
    end

    // fill the write-data FIFO, then free one slot with a write command
    for (int i = 0; i < 4; i++) begin
      push_wdf(fb[i], '0);
      chk(i < 3 ? "wdf_rdy_filling" : "wdf_rdy_full", DW'(app_wdf_rdy), DW'(i < 3));
    end
    send_cmd(CMD_WRITE, 29'h10, '0, 0);
    chk("wdf_rdy_after_pop", DW'(app_wdf_rdy), DW'(1));
    send_cmd(CMD_WRITE, 29'h18, '0, 0);
    send_cmd(CMD_WRITE, 29'h20, '0, 0);
    send_cmd(CMD_WRITE, 29'h28, '0, 0);
    send_cmd(CMD_READ, 29'h28, fb[3], 1);
    send_cmd(CMD_READ, 29'h10, fb[0], 1);
    wait_drain();
    chk("fifo_proto_err", DW'(proto_err), DW'(0));

    // 12 back-to-back reads against the read-pipe occupancy limit
    first_stall = -1;
    valid_base  = n_valid;
    for (int i = 0; i < 12; i++) begin
      if (!app_rdy && first_stall < 0) first_stall = i;
      send_cmd(CMD_READ, rb_addr[i % 8], rb_exp[i % 8], 1);
    end
    wait_drain();
    chk("burst_first_stall", DW'(first_stall), DW'(RD_LAT));
    chk("burst_valid_count", DW'(n_valid - valid_base), DW'(12));

    // write with empty FIFO, then a misaligned read must not overwrite the code
    send_cmd(CMD_WRITE, 29'h60, '0, 0);
    chk("empty_wr_proto_err", DW'(proto_err), DW'(1));
    chk("empty_wr_err_code", DW'(err_code), DW'(1));
    send_cmd(CMD_READ, 29'h43, vecs[4].exp, 1);
    wait_drain();
    chk("misalign_keeps_code", DW'(err_code), DW'(1));

    // reset with a read in flight and a beat in the FIFO
    push_wdf(d_a, '0);
    send_cmd(CMD_READ, 29'h40, vecs[4].exp, 1);
    step();
    step();
    reset_calib(1);
    send_cmd(CMD_WRITE, 29'h50, '0, 0);
    chk("flushed_fifo_proto_err", DW'(proto_err), DW'(1));
    chk("flushed_fifo_err_code", DW'(err_code), DW'(1));

    // unsupported command
    reset_calib(0);
    send_cmd(3'b010, 29'h0, '0, 0);
    chk("bad_cmd_proto_err", DW'(proto_err), DW'(1));
    chk("bad_cmd_err_code", DW'(err_code), DW'(3));
    repeat (RD_LAT + 2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
